// File: rtl/shift_add_multiplier_seq_if.sv
// Start/done handshake bundle for the sequential shift-and-add multiplier.
// The master issues operands and start; the slave returns status and the product.
interface shift_add_multiplier_seq_if #(
    parameter int WIDTH = 1024
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output start, a, b,
        input  ready, busy, done, p
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, p
    );
endinterface

// File: rtl/shift_add_multiplier_seq.sv
// Sequential unsigned shift-and-add multiplier: consumes DIGIT multiplier bits per
// cycle and produces the full 2*WIDTH-bit product with a one-cycle done pulse.
module shift_add_multiplier_seq #(
    parameter int WIDTH      = 1024,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    shift_add_multiplier_seq_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int SW = $clog2(N) + 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [2*WIDTH-1:0]     acc_next;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;
    logic [SW-1:0]          step_reg;
    logic [2*WIDTH-1:0]     p_reg;
    logic                   done_reg;
    logic                   complete;
    logic [2*WIDTH-1:0]     pp_terms [DIGIT];

    // One gated, shifted copy of the multiplicand per consumed multiplier bit.
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_pp
            assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < DIGIT; i++) begin
            acc_next = acc_next + pp_terms[i];
        end
    end

    // Early exit looks at the multiplier bits left after this step's digit.
    assign complete = (state_reg == RUN) &&
                      ((step_reg == LAST_STEP) ||
                       ((EARLY_EXIT != 0) && ((mplier_reg >> DIGIT) == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (complete)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        case (state_reg)
            IDLE:    bus.ready = 1'b1;
            RUN:     bus.busy  = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            step_reg   <= '0;
            p_reg      <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (bus.start) begin
                    acc_reg    <= '0;
                    mcand_reg  <= {{WIDTH{1'b0}}, bus.a};
                    mplier_reg <= bus.b;
                    step_reg   <= '0;
                end
            end else begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << DIGIT;
                mplier_reg <= mplier_reg >> DIGIT;
                step_reg   <= step_reg + SW'(1);
                if (complete) begin
                    p_reg    <= acc_next;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.p    = p_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_shift_add_multiplier_seq.sv
// Bench for shift_add_multiplier_seq: three 8-bit configurations plus a 1024-bit,
// DIGIT=4 instance, checked through a queue scoreboard of expected products.
module tb_shift_add_multiplier_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small instances: 0 = DIGIT1, 1 = DIGIT2, 2 = DIGIT1 with early exit.
    logic [2:0] st8  = '0;
    logic [2:0] rst8 = '1;
    logic [7:0] a8 [3];
    logic [7:0] b8 [3];
    logic [2:0] rdy8, bsy8, dn8;
    logic [15:0] p8 [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_small
            localparam int DG  = (gi == 1) ? 2 : 1;
            localparam int EEX = (gi == 2) ? 1 : 0;
            shift_add_multiplier_seq_if #(.WIDTH(8)) bus ();
            assign bus.start = st8[gi];
            assign bus.a     = a8[gi];
            assign bus.b     = b8[gi];
            assign rdy8[gi]  = bus.ready;
            assign bsy8[gi]  = bus.busy;
            assign dn8[gi]   = bus.done;
            assign p8[gi]    = bus.p;
            shift_add_multiplier_seq #(.WIDTH(8), .DIGIT(DG), .EARLY_EXIT(EEX)) dut (
                .clk (clk),
                .rst (rst8[gi]),
                .bus (bus)
            );
        end
    endgenerate

    // Wide instance.
    logic          st_w  = 1'b0;
    logic          rst_w = 1'b1;
    logic [1023:0] a_w   = '0;
    logic [1023:0] b_w   = '0;
    shift_add_multiplier_seq_if #(.WIDTH(1024)) bus_w ();
    assign bus_w.start = st_w;
    assign bus_w.a     = a_w;
    assign bus_w.b     = b_w;
    shift_add_multiplier_seq #(.WIDTH(1024), .DIGIT(4), .EARLY_EXIT(0)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );

    typedef struct {
        int          inst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        int          lat;
    } exp8_t;

    exp8_t          sb8[$];
    logic [2047:0]  sbw[$];
    vec_t           tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start8(input int i, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        st8[i] = 1'b1; a8[i] = a; b8[i] = b;
        @(negedge clk);
        st8[i] = 1'b0;
    endtask

    // Returns at the negedge where done is seen; lat counts edges after acceptance.
    task automatic wait8(input int i, input int lat0, output int lat, output bit ready_ok);
        lat = lat0;
        ready_ok = 1'b1;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (dn8[i]) begin
                if (!rdy8[i]) ready_ok = 1'b0;
                return;
            end
            if (rdy8[i] || !bsy8[i]) ready_ok = 1'b0;
        end
        chk("done_timeout", 64'(lat), 64'(0));
    endtask

    task automatic run8(input vec_t v, input string name);
        int lat;
        bit rok;
        exp8_t e;
        sb8.push_back('{p: v.p, lat: v.lat});
        start8(v.inst, v.a, v.b);
        wait8(v.inst, 0, lat, rok);
        e = sb8.pop_front();
        $display("op %s inst=%0d a=%0d b=%0d p=%0d lat=%0d", name, v.inst, v.a, v.b, p8[v.inst], lat);
        chk({name, "_p"}, 64'(p8[v.inst]), 64'(e.p));
        chk({name, "_lat"}, 64'(lat), 64'(e.lat));
        chk({name, "_ready"}, 64'(rok), 64'(1));
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic run_w(input logic [1023:0] a, input logic [1023:0] b, input int n);
        int lat;
        logic [2047:0] e;
        sbw.push_back({1024'b0, a} * {1024'b0, b});
        @(negedge clk);
        st_w = 1'b1; a_w = a; b_w = b;
        @(negedge clk);
        st_w = 1'b0;
        a_w = rand1024();
        lat = 0;
        while (lat < 400 && !bus_w.done) begin
            @(negedge clk);
            lat++;
        end
        e = sbw.pop_front();
        $display("op wide#%0d lat=%0d p_lo=%0h", n, lat, bus_w.p[63:0]);
        checks++;
        if (bus_w.p !== e) begin
            errors++;
            $display("FAIL wide_p#%0d: got lo %0h expected lo %0h", n, bus_w.p[63:0], e[63:0]);
        end
        chk("wide_lat", 64'(lat), 64'(256));
    endtask

    initial begin
        int lat;
        bit rok;
        bit bad;

        tbl[0] = '{inst: 0, a: 8'hFF, b: 8'hFF, p: 16'hFE01, lat: 8};
        tbl[1] = '{inst: 1, a: 8'd13, b: 8'd11, p: 16'd143,  lat: 4};
        tbl[2] = '{inst: 1, a: 8'd0,  b: 8'hAB, p: 16'd0,    lat: 4};
        tbl[3] = '{inst: 2, a: 8'd200, b: 8'd3, p: 16'd600,  lat: 2};
        tbl[4] = '{inst: 2, a: 8'd200, b: 8'd0, p: 16'd0,    lat: 1};
        tbl[5] = '{inst: 2, a: 8'h55, b: 8'h80, p: 16'h2A80, lat: 8};
        tbl[6] = '{inst: 0, a: 8'h12, b: 8'h34, p: 16'd936,  lat: 8};
        tbl[7] = '{inst: 1, a: 8'hFF, b: 8'hFF, p: 16'hFE01, lat: 4};
        tbl[8] = '{inst: 2, a: 8'hFF, b: 8'h0F, p: 16'h0EF1, lat: 4};
        for (int i = 0; i < 3; i++) begin a8[i] = '0; b8[i] = '0; end

        repeat (2) @(negedge clk);
        rst8 = '0;
        rst_w = 1'b0;
        $display("reset released");
        chk("rst_p", 64'(p8[0]), 64'(0));
        chk("rst_ready", 64'(rdy8[0]), 64'(1));
        chk("rst_busy", 64'(bsy8[0]), 64'(0));

        // Idle for 20 cycles with start low.
        bad = 1'b0;
        a8[0] = 8'h5A; b8[0] = 8'hA5;
        repeat (20) begin
            @(negedge clk);
            if (!rdy8[0] || bsy8[0] || dn8[0] || p8[0] != 0) bad = 1'b1;
        end
        chk("idle_stable", 64'(bad), 64'(0));

        for (int i = 0; i < 9; i++) run8(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-RUN with a nonzero product held.
        start8(0, 8'd3, 8'd5);
        repeat (3) @(negedge clk);
        #2 rst8[0] = 1'b1;
        #1;
        $display("async reset mid-run inst0 p=%0d ready=%0d busy=%0d", p8[0], rdy8[0], bsy8[0]);
        chk("arst_p", 64'(p8[0]), 64'(0));
        chk("arst_ready", 64'(rdy8[0]), 64'(1));
        chk("arst_busy", 64'(bsy8[0]), 64'(0));
        chk("arst_done", 64'(dn8[0]), 64'(0));
        @(negedge clk);
        rst8[0] = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (dn8[0]) bad = 1'b1;
        end
        chk("arst_no_done", 64'(bad), 64'(0));

        // Ignored start during RUN, then back-to-back start in the done cycle.
        sb8.push_back('{p: 16'd63, lat: 8});
        start8(0, 8'd7, 8'd9);
        @(negedge clk);
        @(negedge clk);
        st8[0] = 1'b1; a8[0] = 8'd1; b8[0] = 8'd1;
        @(negedge clk);
        st8[0] = 1'b0;
        wait8(0, 3, lat, rok);
        begin
            exp8_t e;
            e = sb8.pop_front();
            $display("op b2b_first p=%0d lat=%0d", p8[0], lat);
            chk("b2b1_p", 64'(p8[0]), 64'(e.p));
            chk("b2b1_lat", 64'(lat), 64'(e.lat));
        end
        sb8.push_back('{p: 16'd30, lat: 8});
        st8[0] = 1'b1; a8[0] = 8'd5; b8[0] = 8'd6;
        @(negedge clk);
        st8[0] = 1'b0;
        chk("b2b2_busy", 64'(bsy8[0]), 64'(1));
        chk("b2b2_done_pulse", 64'(dn8[0]), 64'(0));
        chk("b2b2_p_hold", 64'(p8[0]), 64'(63));
        wait8(0, 0, lat, rok);
        begin
            exp8_t e;
            e = sb8.pop_front();
            $display("op b2b_second p=%0d lat=%0d", p8[0], lat);
            chk("b2b2_p", 64'(p8[0]), 64'(e.p));
            chk("b2b2_lat", 64'(lat), 64'(e.lat));
        end

        // Wide instance: abort at step 100, then random products.
        @(negedge clk);
        st_w = 1'b1; a_w = rand1024(); b_w = rand1024();
        @(negedge clk);
        st_w = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_w = 1'b1;
        #1;
        $display("async reset wide mid-run busy=%0d", bus_w.busy);
        chk("wrst_p_zero", 64'(bus_w.p == '0), 64'(1));
        chk("wrst_ready", 64'(bus_w.ready), 64'(1));
        chk("wrst_busy", 64'(bus_w.busy), 64'(0));
        @(negedge clk);
        rst_w = 1'b0;
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (bus_w.done) bad = 1'b1;
        end
        chk("wrst_no_done", 64'(bad), 64'(0));

        for (int n = 0; n < 200; n++) run_w(rand1024(), rand1024(), n);
        run_w({1024{1'b1}}, {1024{1'b1}}, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
